// File: rtl/tmp_pkg.sv
// Shared definitions for the temperature-sensor poll master: FSM encoding,
// peripheral register map and data width.
package tmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WRITE,
        ST_POLL,
        ST_READ,
        ST_DONE
    } tmp_state_e;

    localparam logic        ADDR_CTRL      = 1'b0;
    localparam logic        ADDR_DATA      = 1'b1;
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned TMP_DATA_W     = 8;

    // Control-register word that requests a conversion.
    function automatic logic [31:0] start_word();
        logic [31:0] w;
        w = '0;
        w[CTRL_START_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/tmp_tick_gen.sv
// Terminal-count counter: counts 0..TERMINAL-1 while enabled, flags the last
// count on tc and restarts from zero; clr has priority over en.
module tmp_tick_gen #(
    parameter int unsigned TERMINAL = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned     W    = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [W-1:0]    LAST = W'(TERMINAL - 1);

    logic [W-1:0] count_q, count_d;

    assign tc = en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tmp_poll_master.sv
// Periodically triggers a temperature conversion, polls for completion with a
// timeout, reads the 8-bit code and tracks the running maximum.
module tmp_poll_master
    import tmp_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES  = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear_max,
    output logic                  address,
    output logic                  wr_en,
    output logic [31:0]           wdata,
    input  logic [31:0]           rdata,
    output logic [TMP_DATA_W-1:0] temp_code,
    output logic                  temp_valid,
    output logic [TMP_DATA_W-1:0] temp_max,
    output logic                  timeout_err,
    output logic                  busy
);

    tmp_state_e            state_q, state_d;
    logic                  address_q, address_d;
    logic                  wr_en_q, wr_en_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [TMP_DATA_W-1:0] temp_code_q, temp_code_d;
    logic                  temp_valid_q, temp_valid_d;
    logic [TMP_DATA_W-1:0] temp_max_q, temp_max_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  busy_q, busy_d;

    logic                  period_tc;
    logic                  timeout_tc;
    logic [TMP_DATA_W-1:0] rd_code;
    logic                  unused_rdata_hi;

    assign rd_code         = rdata[TMP_DATA_W-1:0];
    assign unused_rdata_hi = ^rdata[31:TMP_DATA_W];

    // Counters are held clear outside their owning state, so each visit starts at 0.
    tmp_tick_gen #(.TERMINAL(PERIOD_CYCLES)) u_period (
        .clk   (clk),
        .rst_n (rst),
        .clr   ((state_q != ST_WAIT) || !enable),
        .en    ((state_q == ST_WAIT) && enable),
        .tc    (period_tc)
    );

    tmp_tick_gen #(.TERMINAL(TIMEOUT_CYCLES)) u_timeout (
        .clk   (clk),
        .rst_n (rst),
        .clr   (state_q != ST_POLL),
        .en    (state_q == ST_POLL),
        .tc    (timeout_tc)
    );

    always_comb begin
        state_d       = state_q;
        temp_code_d   = temp_code_q;
        temp_max_d    = temp_max_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            ST_IDLE:  if (enable) state_d = ST_WAIT;
            ST_WAIT: begin
                if (!enable)        state_d = ST_IDLE;
                else if (period_tc) state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_POLL;
            ST_POLL: begin
                if (!rdata[CTRL_START_BIT]) begin
                    state_d = ST_READ;
                end else if (timeout_tc) begin
                    state_d       = ST_WAIT;
                    timeout_err_d = 1'b1;
                end
            end
            ST_READ: begin
                temp_code_d = rd_code;
                state_d     = ST_DONE;
            end
            ST_DONE:  state_d = enable ? ST_WAIT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // A capture wins over a simultaneous clear: the new code becomes the max.
        if ((state_q == ST_READ) && (clear_max || (rd_code > temp_max_q))) begin
            temp_max_d = rd_code;
        end else if (clear_max) begin
            temp_max_d = '0;
        end

        // Outputs are decoded from the next state so they register in step with it.
        address_d    = (state_d == ST_READ) ? ADDR_DATA : ADDR_CTRL;
        wr_en_d      = (state_d == ST_WRITE);
        wdata_d      = wr_en_d ? start_word() : '0;
        temp_valid_d = (state_d == ST_DONE);
        busy_d       = (state_d == ST_WRITE) || (state_d == ST_POLL) || (state_d == ST_READ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            address_q     <= ADDR_CTRL;
            wr_en_q       <= 1'b0;
            wdata_q       <= '0;
            temp_code_q   <= '0;
            temp_valid_q  <= 1'b0;
            temp_max_q    <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            wr_en_q       <= wr_en_d;
            wdata_q       <= wdata_d;
            temp_code_q   <= temp_code_d;
            temp_valid_q  <= temp_valid_d;
            temp_max_q    <= temp_max_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign address     = address_q;
    assign wr_en       = wr_en_q;
    assign wdata       = wdata_q;
    assign temp_code   = temp_code_q;
    assign temp_valid  = temp_valid_q;
    assign temp_max    = temp_max_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_tmp_poll_master.sv
// Scoreboard bench for tmp_poll_master with a behavioural sensor peripheral
// whose start bit clears a programmable number of cycles after the write.
module tb_tmp_poll_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear_max;
    logic        address;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  temp_code;
    logic        temp_valid;
    logic [7:0]  temp_max;
    logic        timeout_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_wr_cyc = 0;
    int wr_count = 0;
    logic prev_valid = 1'b0;

    // Peripheral model configuration
    logic [7:0] mdl_delay = 8'd0;
    logic       mdl_never = 1'b0;
    logic [7:0] mdl_data  = 8'h00;
    logic       mdl_start;
    logic [7:0] mdl_cnt;

    typedef struct {
        logic [7:0] code;
        logic [7:0] max;
        int         lat;
    } exp_t;
    exp_t sb[$];

    tmp_poll_master #(.PERIOD_CYCLES(16), .TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear_max   (clear_max),
        .address     (address),
        .wr_en       (wr_en),
        .wdata       (wdata),
        .rdata       (rdata),
        .temp_code   (temp_code),
        .temp_valid  (temp_valid),
        .temp_max    (temp_max),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rdata = address ? {24'hDEADBE, mdl_data} : {31'b0, mdl_start};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdl_start <= 1'b0;
            mdl_cnt   <= 8'd0;
        end else if (wr_en && wdata[0]) begin
            mdl_start <= mdl_never || (mdl_delay != 8'd0);
            mdl_cnt   <= mdl_delay;
        end else if (mdl_start && !mdl_never) begin
            if (mdl_cnt <= 8'd1) mdl_start <= 1'b0;
            mdl_cnt <= mdl_cnt - 8'd1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] code, input logic [7:0] max, input int lat);
        exp_t e;
        e.code = code;
        e.max  = max;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Monitor: checks every write strobe and scores every temp_valid pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                chk("wr_strobe", {31'b0, address, wdata}, 64'h1);
                last_wr_cyc = cyc;
                wr_count++;
            end
            if (temp_valid) begin
                chk("valid_one_cycle", prev_valid, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("temp_code", temp_code, e.code);
                    chk("temp_max", temp_max, e.max);
                    chk("valid_latency", cyc - last_wr_cyc, e.lat);
                end
            end
        end
        prev_valid = rst && temp_valid;
    end

    task automatic wait_wr(output int n, output int at);
        n  = 0;
        at = -1;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (wr_en) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("wr_wait_expired", 0, 1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (temp_valid) break;
        end
        if (!temp_valid) chk("valid_wait_expired", 0, 1);
    endtask

    initial begin
        int n, at, at2, polls, w0;
        rst = 1'b0;
        enable = 1'b0;
        clear_max = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {address, wr_en, wdata, temp_code, temp_valid, temp_max, timeout_err, busy}, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_wr", {wr_count, 7'b0, busy}, 0);

        // First sample: start clears 2 cycles after the write
        mdl_delay = 8'd2; mdl_never = 1'b0; mdl_data = 8'h3A;
        push_exp(8'h3A, 8'h3A, 5);
        enable = 1'b1;
        wait_wr(n, at);
        chk("first_wr_delay", n, 17);
        wait_valid();

        // Larger sample then smaller sample, immediate clear
        mdl_delay = 8'd0; mdl_data = 8'h50;
        push_exp(8'h50, 8'h50, 3);
        wait_wr(n, at2);
        chk("period_gap", at2 - at, 22);
        wait_valid();
        mdl_data = 8'h20;
        push_exp(8'h20, 8'h50, 3);
        wait_wr(n, at);
        wait_valid();
        clear_max = 1'b1;
        @(negedge clk);
        clear_max = 1'b0;
        chk("clear_max", temp_max, 8'h00);

        // Peripheral never clears start: timeout path
        mdl_never = 1'b1;
        wait_wr(n, at);
        polls = 0;
        @(negedge clk);
        while (busy && polls < 50) begin
            polls++;
            @(negedge clk);
        end
        chk("poll_cycles", polls, 8);
        chk("timeout_set", timeout_err, 1);
        chk("code_kept_on_timeout", temp_code, 8'h20);
        mdl_never = 1'b0; mdl_delay = 8'd0; mdl_data = 8'h44;
        push_exp(8'h44, 8'h44, 3);
        wait_wr(n, at2);
        chk("gap_after_timeout", at2 - at, 25);
        wait_valid();
        chk("timeout_sticky", timeout_err, 1);

        // enable dropped during POLL: completes, then idles
        mdl_delay = 8'd2; mdl_data = 8'h66;
        push_exp(8'h66, 8'h66, 5);
        wait_wr(n, at);
        @(negedge clk);
        enable = 1'b0;
        wait_valid();
        @(negedge clk);
        chk("idle_after_drop", busy, 0);
        w0 = wr_count;
        repeat (40) @(negedge clk);
        chk("no_wr_while_disabled", wr_count - w0, 0);
        mdl_never = 1'b1;
        enable = 1'b1;
        wait_wr(n, at);
        chk("reenable_wr_delay", n, 17);

        // Reset asserted mid-POLL
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_mid_poll", {address, wr_en, wdata, temp_code, temp_valid, temp_max, timeout_err, busy}, 0);
        repeat (3) @(negedge clk);
        mdl_never = 1'b0; mdl_delay = 8'd0; mdl_data = 8'h7F;
        push_exp(8'h7F, 8'h7F, 3);
        rst = 1'b1;
        wait_wr(n, at);
        chk("post_reset_wr_delay", n, 17);
        wait_valid();

        // clear_max coincident with the READ capture
        mdl_data = 8'h11;
        push_exp(8'h11, 8'h11, 3);
        wait_wr(n, at);
        @(negedge clk);
        @(negedge clk);
        chk("read_phase_address", address, 1);
        clear_max = 1'b1;
        @(negedge clk);
        clear_max = 1'b0;
        chk("valid_after_read", temp_valid, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmp_poll_master.md
TMP_POLL_MASTER -- requirements
Module: tmp_poll_master

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 100000000, meaning cycles between sample triggers (1 s at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning max cycles to wait for the peripheral to clear the start bit.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  level; 1 allows periodic sampling.
REQ-006 SHALL have port clear_max  input  1  one-cycle pulse; clears temp_max.
REQ-007 SHALL have port address  output  1  peripheral register select; 0 = control, 1 = data.
REQ-008 SHALL have port wr_en  output  1  peripheral write strobe.
REQ-009 SHALL have port wdata  output  32  peripheral write data.
REQ-010 SHALL have port rdata  input  32  peripheral read data, combinational from address.
REQ-011 SHALL have port temp_code  output  8  last captured ADC code.
REQ-012 SHALL have port temp_valid  output  1  one-cycle pulse on each new temp_code.
REQ-013 SHALL have port temp_max  output  8  highest code since reset or clear_max.
REQ-014 SHALL have port timeout_err  output  1  sticky; set on poll timeout.
REQ-015 SHALL have port busy  output  1  high in WRITE, POLL and READ states.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, WRITE, POLL, READ, DONE.
REQ-017 IDLE: address=0, wr_en=0, wdata=0; go to WAIT when enable=1, period counter cleared.
REQ-018 WAIT: period counter counts 0..PERIOD_CYCLES-1; at terminal count go to WRITE; enable=0 goes to IDLE next cycle and clears counter.
REQ-019 WRITE: exactly one cycle with address=0, wr_en=1, wdata=32'h0000_0001 (bit0 = start); then POLL.
REQ-020 POLL: address=0, wr_en=0; each cycle sample rdata[0]; rdata[0]=0 goes to READ; timeout counter counts from 0.
REQ-021 POLL timeout: if rdata[0] is still 1 after TIMEOUT_CYCLES poll cycles, set timeout_err, leave temp_code unchanged, return to WAIT with counter cleared.
REQ-022 READ: one cycle with address=1; capture rdata[7:0] into temp_code at the end of the cycle; then DONE; rdata[31:8] ignored.
REQ-023 DONE: temp_valid=1 for this single cycle; go to WAIT if enable=1, else IDLE.
REQ-024 Latency: with immediate clear, the start write is followed by temp_valid 3 cycles later (POLL, READ, DONE); temp_code is already updated when temp_valid is high.
REQ-025 enable deasserted in WRITE/POLL/READ/DONE SHALL NOT abort; the transaction completes, then the FSM returns to IDLE.
REQ-026 temp_max update: on the READ capture edge, load rdata[7:0] if it is strictly greater than temp_max (unsigned compare).
REQ-027 clear_max alone SHALL set temp_max=0 next cycle; clear_max coincident with the READ capture SHALL load the captured code.
REQ-028 timeout_err SHALL clear only on reset; later successful samples do not clear it.
REQ-029 Counters SHALL be sized $clog2 of their parameter and SHALL NOT wrap silently; the terminal count always causes a state change.

Reset
REQ-030 On rst=0, asynchronously: state=IDLE, both counters=0, address=0, wr_en=0, wdata=0, temp_code=0, temp_valid=0, temp_max=0, timeout_err=0, busy=0.
REQ-031 Reset mid-transaction (e.g. in POLL) SHALL abandon it with no further wr_en; after release, normal operation restarts from IDLE.

Structure
REQ-032 Shared package tmp_pkg SHALL hold: FSM state enum, ADDR_CTRL=0, ADDR_DATA=1, CTRL_START_BIT=0, TMP_DATA_W=8.
REQ-033 Sub-module tmp_tick_gen (parameterised terminal-count counter with clear and enable) SHALL be used for both the period counter and the timeout counter.

Verification (PERIOD_CYCLES=16, TIMEOUT_CYCLES=8, behavioural peripheral model)
REQ-034 Model clears start 2 cycles after write, data=8'h3A -> one wr_en pulse with wdata=1 after 16 WAIT cycles; temp_code=8'h3A; temp_valid one cycle; temp_max=8'h3A.
REQ-035 Samples 8'h50 then 8'h20 -> temp_max stays 8'h50; temp_code=8'h20; then clear_max pulse -> temp_max=0.
REQ-036 Model never clears start -> exactly 8 POLL cycles, timeout_err=1, no temp_valid, next wr_en 16 cycles later; timeout_err still 1 after a later good sample.
REQ-037 enable dropped during POLL -> transaction completes with temp_valid, FSM enters IDLE, no further wr_en until enable returns.
REQ-038 rst asserted during POLL -> all outputs 0 immediately; after release with enable=1, first wr_en occurs after 16 WAIT cycles.
REQ-039 clear_max asserted on the READ capture cycle with data 8'h11 and prior max 8'h7F -> temp_max=8'h11.
